muldiv_seq: RTL and testbench

Iterative unsigned multiply/divide sequencer for the MIPS core's `multu`/`divu` instructions and the HI/LO registers. It does not contain an adder. Instead, it drives the shared 32-bit ALU (`addu`/`subu` operations) through 32 single-bit iterations and captures each result. It sits beside the datapath, which hands it the rs and rt operands and stalls on `busy`.

---
 rtl/muldiv_seq.sv | 144 ++++++++++++++
 tb/tb_muldiv_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative unsigned multu/divu sequencer driving the shared ALU.
// Each MUL/DIV cycle issues one addu/subu on the external ALU and folds the
// result into HI/LO. The operation completes after 32 iterations.
// Build option: define MULDIV_DIV_EN to build the restoring divider. Without
// it, divu finishes immediately with HI = LO = 0.
module muldiv_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [1:0]  alu_ctl,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_c
);

`ifdef MULDIV_DIV_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] opnd_q, opnd_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        mul_carry;
`ifdef MULDIV_DIV_EN
    logic        div_t;
    logic [31:0] div_r;
`endif

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, iteration step and ALU drive
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        alu_ctl   = 2'b00;
        alu_a     = '0;
        alu_b     = '0;
        // ALU carry-out is recovered from the wrapped sum
        mul_carry = (alu_c < hi_q);
`ifdef MULDIV_DIV_EN
        div_t     = hi_q[31];
        div_r     = {hi_q[30:0], lo_q[31]};
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    hi_d  = '0;
                    cnt_d = '0;
                    if (!op) begin
                        lo_d    = rs_val;
                        opnd_d  = rt_val;
                        state_d = S_MUL;
                    end else begin
`ifdef MULDIV_DIV_EN
                        lo_d    = rs_val;
                        opnd_d  = rt_val;
                        state_d = S_DIV;
`else
                        lo_d    = '0;
                        state_d = S_DONE;
`endif
                    end
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                alu_ctl = 2'b00;
                alu_a   = hi_q;
                alu_b   = opnd_q;
                if (lo_q[0]) begin
                    {hi_d, lo_d} = {mul_carry, alu_c, lo_q[31:1]};
                end else begin
                    {hi_d, lo_d} = {1'b0, hi_q, lo_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                end
            end
`ifdef MULDIV_DIV_EN
            S_DIV: begin
                alu_ctl = 2'b01;
                alu_a   = div_r;
                alu_b   = opnd_q;
                // div_t is the bit shifted out of r; when set, r+2^32 >= divisor
                if (div_t || (div_r >= opnd_q)) begin
                    hi_d = alu_c;
                    lo_d = {lo_q[30:0], 1'b1};
                end else begin
                    hi_d = div_r;
                    lo_d = {lo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef MULDIV_DIV_EN
    assign busy = (state_q == S_MUL) || (state_q == S_DIV);
`else
    assign busy = (state_q == S_MUL);
`endif
    assign done = (state_q == S_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed bench for muldiv_seq with a behavioural ALU and a
// scoreboard of expected HI/LO, latency and busy-cycle counts.
module tb_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  alu_ctl;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_c;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          bsy;
        logic [1:0]  ctl;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    muldiv_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .alu_ctl (alu_ctl),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_c   (alu_c)
    );

    // Shared ALU: addu / subu
    assign alu_c = (alu_ctl == 2'b01) ? (alu_a - alu_b) : (alu_a + alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        if (!o) begin
            p     = {32'b0, a} * {32'b0, b};
            e.hi  = p[63:32];
            e.lo  = p[31:0];
            e.lat = 33;
            e.bsy = 32;
            e.ctl = 2'b00;
        end else begin
`ifdef MULDIV_DIV_EN
            if (b == 32'd0) begin
                e.hi = a;
                e.lo = 32'hFFFF_FFFF;
            end else begin
                e.hi = a % b;
                e.lo = a / b;
            end
            e.lat = 33;
            e.bsy = 32;
            e.ctl = 2'b01;
`else
            e.hi  = 32'd0;
            e.lo  = 32'd0;
            e.lat = 1;
            e.bsy = 0;
            e.ctl = 2'b00;
`endif
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        assert (got === expv) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // Drive a request (caller is positioned away from the rising edge)
    task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        sb.push_back(model(o, a, b));
    endtask

    // Let the request be accepted, then track the run until done (bounded)
    task automatic finish_op(input string tag, input int glitch);
        exp_t e;
        int   lat;
        int   bsy;
        int   ctlerr;
        bit   seen;
        e = sb.pop_front();
        @(posedge clk);
        #1 start = 1'b0;
        lat    = 0;
        bsy    = 0;
        ctlerr = 0;
        seen   = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                lat  = k;
            end else begin
                if (busy) begin
                    bsy++;
                    if (alu_ctl !== e.ctl) ctlerr++;
                end
                if (k == glitch) begin
                    start  = 1'b1;
                    op     = 1'b0;
                    rs_val = 32'hDEAD_BEEF;
                    rt_val = 32'h0BAD_F00D;
                end else if (k == glitch + 1) begin
                    start = 1'b0;
                end
            end
        end
        chk({tag, "_latency"}, 64'(lat), 64'(e.lat));
        chk({tag, "_busy_cycles"}, 64'(bsy), 64'(e.bsy));
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, "_alu_ctl_errs"}, 64'(ctlerr), 64'd0);
        chk({tag, "_hi"}, 64'(hi), 64'(e.hi));
        chk({tag, "_lo"}, 64'(lo), 64'(e.lo));
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        op     = 1'b0;
        rs_val = '0;
        rt_val = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        chk("reset_alu", {30'd0, alu_ctl, alu_a}, 64'd0);
        chk("reset_alu_b", 64'(alu_b), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic multiply, then check done is a single pulse and results hold
        issue(1'b0, 32'd3, 32'd5);
        finish_op("mul_3x5", 0);
        @(negedge clk);
        chk("mul_3x5_done_pulse", 64'(done), 64'd0);
        chk("mul_3x5_hold", {hi, lo}, 64'd15);
        chk("idle_alu", {30'd0, alu_ctl, alu_a}, 64'd0);

        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op("mul_full", 0);
        @(negedge clk);

        issue(1'b1, 32'd100, 32'd7);
        finish_op("div_100_7", 0);
        @(negedge clk);

        issue(1'b1, 32'hFFFF_FFFF, 32'h8000_0001);
        finish_op("div_tpath", 0);
        @(negedge clk);

        issue(1'b1, 32'h0000_1234, 32'd0);
        finish_op("div_by_zero", 0);
        @(negedge clk);

        // Start pulsed during busy must be ignored
        issue(1'b0, 32'h0001_2345, 32'h0000_6789);
        finish_op("mul_ignore_start", 10);

        // Back-to-back: request raised in the DONE cycle is taken at E33
        issue(1'b0, 32'hABCD_0123, 32'h0000_0011);
        finish_op("b2b_first", 0);
        issue(1'b1, 32'h8765_4321, 32'h0000_0123);
        finish_op("b2b_second", 0);
        @(negedge clk);

        // Reset in the middle of an operation
`ifdef MULDIV_DIV_EN
        issue(1'b1, 32'hFFFF_0000, 32'h0000_0003);
`else
        issue(1'b0, 32'hFFFF_0000, 32'h0000_0003);
`endif
        void'(sb.pop_front());
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        chk("pre_reset_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_done", 64'(done), 64'd0);
        chk("midreset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_done", 64'(done), 64'd0);
        issue(1'b0, 32'd7, 32'd6);
        finish_op("mul_7x6", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
